// File: rtl/xgriscv_lsu.sv
// Load/store unit: core data port to valid/ready word bus, lane steering, load extension, timeout.
// Optional misaligned-access trap selected by XGRISCV_LSU_MISALIGN_TRAP_EN (default: force alignment).
module xgriscv_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int              CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t            r_state, w_state_nxt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept, w_bad_code, w_misalign, w_illegal, w_timeout;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_lane, w_load;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_bad_code = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
  assign w_illegal  = w_bad_code || w_misalign;
`else
  assign w_illegal  = w_bad_code;
`endif
  assign w_timeout  = TO_EN && (r_cnt == CNT_LAST);

  // Lane offset is already naturally aligned, so misaligned h/w are silently fixed here.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_off   = req_addr[1:0];
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_off   = {req_addr[1], 1'b0};
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_lane;
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A response word that lands on the timeout cycle still wins in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: if (w_timeout) w_state_nxt = S_RESP;
               else if (bus_ready) w_state_nxt = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (bus_rvalid || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    bus_valid  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE:  req_ready  = 1'b1;
      S_ISSUE: bus_valid  = !w_timeout;
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus_we     = r_we;
  assign bus_addr   = r_addr;
  assign bus_be     = r_be;
  assign bus_wdata  = r_wdata;
  assign resp_rdata = resp_valid ? r_rdata : 32'd0;
  assign resp_err   = resp_valid && r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_addr   <= '0;
      r_be     <= 4'b0000;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_off    <= w_off;
        r_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_rdata  <= 32'd0;
        r_err    <= w_illegal;
      end
      case (r_state)
        S_ISSUE: if (w_timeout) r_err <= 1'b1;
        S_WAIT: begin
          if (bus_rvalid)     r_rdata <= w_load;
          else if (w_timeout) r_err   <= 1'b1;
        end
        default: ;
      endcase
      if (r_state == S_IDLE)                             r_cnt <= '0;
      else if (r_state == S_ISSUE || r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/xgriscv_lsu.md
Name: xgriscv_lsu

Overview:
- Load/store unit between the xgriscv core's data-side outputs and a word-wide data-memory bus with valid/ready request and read-data-valid response.
- Generates byte enables and replicated write data, aligns and sign/zero-extends load data, and supervises the bus transaction with an FSM and timeout.
- Lets the data memory have variable latency instead of the combinational single-cycle dmem.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in ISSUE+WAIT before an error response; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (low bits significant).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  error qualifier, valid with resp_valid.
- bus_valid  out  1  bus request valid.
- bus_ready  in  1  bus accepts request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated write data.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0 except req_ready=1. Timeout counter=0. A reset mid-transaction abandons it with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid; capture we, funct3, addr, wdata.
  - Illegal request (funct3 011/110/111, or store with funct3[2]=1): go to RESP with err=1; no bus access.
  - Otherwise go to ISSUE.
- ISSUE:
  - bus_valid=1. bus_we/addr/be/wdata are held stable until bus_ready.
  - On bus_ready: store goes to RESP; load goes to WAIT.
- WAIT: on bus_rvalid, capture the extended data and go to RESP. bus_rvalid outside WAIT is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Byte enables:
  - b/bu: 4'b0001<<addr[1:0].
  - h/hu: 4'b0011<<{addr[1],1'b0}.
  - w: 4'b1111.
- Write data:
  - byte store: wdata[7:0] replicated ×4.
  - half store: wdata[15:0] replicated ×2.
  - word store: wdata unchanged.
- Load data: rdata shifted right by 8*addr[1:0]. b/h sign-extend; bu/hu zero-extend; w unchanged.
- Timeout:
  - Counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES (≠0), go to RESP with err=1 and rdata=0. bus_valid drops in that same cycle.
- Minimum latency (accept = cycle 0):
  - store: resp at cycle 2.
  - load: resp at cycle 3, with ready at cycle 1 and rvalid at cycle 2.
- Back-to-back: next request accepted the cycle after RESP, so throughput is one access per 3 (store) / 4 (load) cycles minimum.

Optional Feature:
- Macro: XGRISCV_LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, is an error. It gets an IDLE→RESP err=1 response with no bus access.
- Undefined: misaligned addresses are forced to natural alignment (h clears addr[0], w clears addr[1:0]) and proceed normally with err=0.

Test Plan:
- sb addr=0x103 wdata=0x000000AB, bus_ready immediate → bus_addr=0x100, be=1000, wdata=0xABABABAB, resp_valid at cycle 2, err=0.
- lb addr=0x102, bus_rdata=0x00800000, rvalid one cycle after ready → resp_rdata=0xFFFFFF80. Same with lbu → 0x00000080.
- lh addr=0x2, bus_ready held low 5 cycles → bus_valid, bus_addr=0x0, be=1100 stable throughout. rdata=0x8001xxxx → resp_rdata=0xFFFF8001.
- Load with TIMEOUT_CYCLES=8, bus_rvalid never asserted → resp_valid with err=1, rdata=0 exactly 8 cycles after entering ISSUE. A late rvalid afterwards has no effect.
- funct3=011 request → resp_valid 1 cycle after accept, err=1, bus_valid never asserted. lw addr=0x6: with macro → err=1, no bus access; without macro → bus_addr=0x4, err=0.
- Reset deasserted→asserted (0) while in WAIT → outputs return to reset values immediately. After release, a new sw 0x10 completes normally with be=1111.
